// File: rtl/intr_pulse_latch.sv
// Turns a debounced one-shot button pulse into a level interrupt request held until
// acknowledged, followed by a fixed re-arm lockout; presses arriving while busy are counted.
module intr_pulse_latch #(
  parameter int LOCKOUT_CLKS = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 intr_en,
  input  logic                 intr_ack,
  input  logic                 clr_missed,
  output logic                 intr,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic [7:0]           missed_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CLKS - 1);

  state_t     ps;
  state_t     ns;
  logic       pulse_d;
  logic       rise;
  logic       accept;
  logic       missed;
  logic [7:0] lock_cnt;

  // Request handshake: intr is a level that stays high while pending and enabled;
  // the CPU retires it with a one-cycle intr_ack, which only counts while intr_en is high.
  assign rise   = pulse_in & ~pulse_d;
  assign accept = rise & (ps == ST_IDLE);
  assign missed = rise & ((ps == ST_PENDING) | (ps == ST_LOCKOUT));
  assign state  = ps;

  always_comb begin
    intr = (ps == ST_PENDING) & intr_en;
  end

  always_comb begin
    ns = ps;
    case (ps)
      ST_IDLE:    if (rise) ns = ST_PENDING;
      ST_PENDING: if (intr_ack && intr_en) ns = ST_LOCKOUT;
      ST_LOCKOUT: if (lock_cnt == LOCK_LAST) ns = ST_IDLE;
      default:    ns = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps         <= ST_IDLE;
      pulse_d    <= 1'b0;
      lock_cnt   <= 8'd0;
      press_cnt  <= '0;
      missed_cnt <= 8'd0;
    end else begin
      ps      <= ns;
      pulse_d <= pulse_in;

      if (ps == ST_PENDING && ns == ST_LOCKOUT)
        lock_cnt <= 8'd0;
      else if (ps == ST_LOCKOUT)
        lock_cnt <= lock_cnt + 8'd1;

      if (accept)
        press_cnt <= press_cnt + CNT_WIDTH'(1);

      // A clear in the same cycle as a missed press wins.
      if (clr_missed)
        missed_cnt <= 8'd0;
      else if (missed && missed_cnt != 8'hFF)
        missed_cnt <= missed_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_intr_pulse_latch.sv
// Bench for intr_pulse_latch: scenario tasks with inline checks and a queue of
// expected press counts consumed when the interrupt request appears.
module tb_intr_pulse_latch;

  localparam int         LOCK = 16;
  localparam int         CW   = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic          intr_en;
  logic          intr_ack;
  logic          clr_missed;
  logic          intr;
  logic [CW-1:0] press_cnt;
  logic [7:0]    missed_cnt;
  logic [1:0]    state;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_press;
  logic [CW-1:0] exp_v;
  int            errors;
  int            checks;

  intr_pulse_latch #(.LOCKOUT_CLKS(LOCK), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .intr_en    (intr_en),
    .intr_ack   (intr_ack),
    .clr_missed (clr_missed),
    .intr       (intr),
    .press_cnt  (press_cnt),
    .missed_cnt (missed_cnt),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_intr(input int limit, output int cycles);
    cycles = 0;
    while (intr !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  // Drive a press edge and record the press count it should produce.
  task automatic start_press();
    pulse_in  = 1'b1;
    exp_press = exp_press + 1'b1;
    exp_q.push_back(exp_press);
  endtask

  task automatic pop_expected(input string name);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty queue expected an entry", name);
    end else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (press_cnt !== exp_v) begin
        errors++;
        $display("FAIL %s_press_cnt: got %0d expected %0d", name, press_cnt, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %0b expected 0", intr); end
    checks++; if (press_cnt !== 8'd0) begin errors++; $display("FAIL reset_press: got %0d expected 0", press_cnt); end
    checks++; if (missed_cnt !== 8'd0) begin errors++; $display("FAIL reset_missed: got %0d expected 0", missed_cnt); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    rst_n = 1'b1;
    tick();
    intr_en  = 1'b1;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL pre_reset_intr: got %0b expected 1", intr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL async_reset_intr: got %0b expected 0", intr); end
    checks++; if (press_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_press: got %0d expected 0", press_cnt); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL async_reset_state: got %0d expected %0d", state, S_IDLE); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL post_release_intr: got %0b expected 0", intr); end
    exp_press = '0;
  endtask

  task automatic test_single_press();
    int cyc;
    start_press();
    wait_intr(4, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", cyc); end
    pop_expected("single");
    repeat (2) tick();
    pulse_in = 1'b0;
    repeat (7) tick();
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL single_held: got %0b expected 1", intr); end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_ack_drop: got %0b expected 0", intr); end
    checks++; if (state !== S_LOCK) begin errors++; $display("FAIL single_lock_state: got %0d expected %0d", state, S_LOCK); end
    checks++; if (missed_cnt !== 8'd0) begin errors++; $display("FAIL single_missed: got %0d expected 0", missed_cnt); end
    repeat (LOCK + 2) tick();
  endtask

  task automatic test_masked_ack();
    intr_en = 1'b0;
    start_press();
    tick();
    pulse_in = 1'b0;
    checks++; if (state !== S_PEND) begin errors++; $display("FAIL masked_state: got %0d expected %0d", state, S_PEND); end
    pop_expected("masked");
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL masked_intr: got %0b expected 0", intr); end
    checks++; if (state !== S_PEND) begin errors++; $display("FAIL masked_ack_state: got %0d expected %0d", state, S_PEND); end
    intr_en = 1'b1;
    #1;
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL unmask_intr: got %0b expected 1", intr); end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    repeat (LOCK + 2) tick();
  endtask

  task automatic test_lockout_boundary();
    int cyc;
    // rise sampled LOCK edges after the ack edge: still locked out
    start_press();
    wait_intr(4, cyc);
    pop_expected("lock_a");
    pulse_in = 1'b0;
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    repeat (LOCK - 1) tick();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    checks++; if (missed_cnt !== 8'd1) begin errors++; $display("FAIL lock_edge_missed: got %0d expected 1", missed_cnt); end
    checks++; if (press_cnt !== exp_press) begin errors++; $display("FAIL lock_edge_press: got %0d expected %0d", press_cnt, exp_press); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lock_edge_intr: got %0b expected 0", intr); end
    tick();
    // rise sampled LOCK+1 edges after the ack edge: accepted
    start_press();
    wait_intr(4, cyc);
    pop_expected("lock_b");
    pulse_in = 1'b0;
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    repeat (LOCK) tick();
    start_press();
    tick();
    pulse_in = 1'b0;
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL rearm_intr: got %0b expected 1", intr); end
    checks++; if (missed_cnt !== 8'd1) begin errors++; $display("FAIL rearm_missed: got %0d expected 1", missed_cnt); end
    pop_expected("rearm");
  endtask

  task automatic test_saturation();
    int cyc;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_press = '0;
    tick();
    start_press();
    wait_intr(4, cyc);
    pop_expected("sat_first");
    pulse_in = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      tick();
      if (i == 9) begin
        checks++; if (missed_cnt !== 8'd10) begin errors++; $display("FAIL sat_partial: got %0d expected 10", missed_cnt); end
      end
    end
    checks++; if (missed_cnt !== 8'hFF) begin errors++; $display("FAIL sat_missed: got %0d expected 255", missed_cnt); end
    checks++; if (press_cnt !== 8'd1) begin errors++; $display("FAIL sat_press: got %0d expected 1", press_cnt); end
    clr_missed = 1'b1;
    pulse_in   = 1'b1;
    tick();
    clr_missed = 1'b0;
    pulse_in   = 1'b0;
    checks++; if (missed_cnt !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", missed_cnt); end
    tick();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    checks++; if (missed_cnt !== 8'd1) begin errors++; $display("FAIL after_clr: got %0d expected 1", missed_cnt); end
    tick();
  endtask

  task automatic test_rise_with_ack();
    pulse_in = 1'b1;
    intr_ack = 1'b1;
    tick();
    pulse_in = 1'b0;
    intr_ack = 1'b0;
    checks++; if (state !== S_LOCK) begin errors++; $display("FAIL simul_state: got %0d expected %0d", state, S_LOCK); end
    checks++; if (missed_cnt !== 8'd2) begin errors++; $display("FAIL simul_missed: got %0d expected 2", missed_cnt); end
    checks++; if (press_cnt !== exp_press) begin errors++; $display("FAIL simul_press: got %0d expected %0d", press_cnt, exp_press); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL simul_intr: got %0b expected 0", intr); end
    repeat (LOCK) tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL simul_rearm: got %0d expected %0d", state, S_IDLE); end
  endtask

  task automatic test_random_presses();
    int cyc;
    int len;
    int dly;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(1, 4);
      dly = $urandom_range(0, 5);
      start_press();
      wait_intr(4, cyc);
      checks++; if (cyc != 1) begin errors++; $display("FAIL rand_latency_%0d: got %0d expected 1", n, cyc); end
      pop_expected("rand");
      repeat (len - 1) tick();
      pulse_in = 1'b0;
      repeat (dly) tick();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rand_ack_%0d: got %0b expected 0", n, intr); end
      repeat (LOCK) tick();
    end
    checks++; if (missed_cnt !== 8'd2) begin errors++; $display("FAIL rand_missed: got %0d expected 2", missed_cnt); end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    exp_press  = '0;
    rst_n      = 1'b0;
    pulse_in   = 1'b0;
    intr_en    = 1'b0;
    intr_ack   = 1'b0;
    clr_missed = 1'b0;

    test_reset();
    test_single_press();
    test_masked_ack();
    test_lockout_boundary();
    test_saturation();
    test_rise_with_ack();
    test_random_presses();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
